// File: rtl/ft6_read.sv
`default_nettype none
// ============================================================================
//  Module   : ft6_read
//  Purpose  : Host->FPGA receive path of the FT601 32-bit 245-synchronous
//             FIFO bus. Drives OE_N/RD_N to drain words offered on RXF_N,
//             buffers them in a DEPTH-word first-word-fall-through FIFO and
//             presents them on a valid/ready stream.
//  Ports    : ft6_clk, rst_n          clock / async active-low reset
//             ft6_rxf_n               FT601 has data (active low)
//             ft6_data_in, ft6_be_in  FT601 bus, input half
//             ft6_oe_n, ft6_rd_n      registered bus controls (active low)
//             out_data, out_be        head-of-FIFO word / byte enables
//             out_valid, out_ready    downstream handshake
//             level                   words currently buffered
//             rx_count                words captured from the FT601 (wraps)
//             ovf                     sticky overflow flag
//  Revision : 1.0  initial release
// ============================================================================
module ft6_read #(
  parameter int DEPTH     = 8,
  parameter int RD_MARGIN = 2,
  parameter int DW        = 32
) (
  input  logic                       ft6_clk,
  input  logic                       rst_n,
  input  logic                       ft6_rxf_n,
  input  logic [DW-1:0]              ft6_data_in,
  input  logic [DW/8-1:0]            ft6_be_in,
  output logic                       ft6_oe_n,
  output logic                       ft6_rd_n,
  output logic [DW-1:0]              out_data,
  output logic [DW/8-1:0]            out_be,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [31:0]                rx_count,
  output logic                       ovf
);

  localparam int BEW = DW / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int FW  = DW + BEW;

  localparam logic [LW-1:0] C_LVL_FULL  = LW'(DEPTH);
  // free >= RD_MARGIN  <=>  level <= DEPTH - RD_MARGIN
  localparam logic [LW-1:0] C_LVL_LIMIT = LW'(DEPTH - RD_MARGIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OE   = 2'd1,
    ST_READ = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_oe_n;
  logic            r_rd_n;

  logic [FW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [31:0]     r_rx_count;
  logic            r_ovf;

  logic            w_room;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr_en;

  assign w_room  = (r_level <= C_LVL_LIMIT);
  // Capture uses the registered strobe, so a push lands exactly on edges
  // where the FT601 saw RD_N low together with its own RXF_N low.
  assign w_push  = !r_rd_n && !ft6_rxf_n;
  assign w_pop   = (r_level != '0) && out_ready;
  assign w_full  = (r_level == C_LVL_FULL);
  // A full FIFO can still take a word when the head leaves on the same edge.
  assign w_wr_en = w_push && (!w_full || w_pop);

  // --------------------------------------------------------------------------
  // Bus control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!ft6_rxf_n && w_room) w_state_nxt = ST_OE;
      ST_OE:   w_state_nxt = ST_READ;
      ST_READ: if (ft6_rxf_n || !w_room) w_state_nxt = ST_TURN;
      ST_TURN: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // OE_N/RD_N are decoded from the next state so they are glitch-free
  // flops that always match the state register.
  always_ff @(posedge ft6_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_oe_n  <= 1'b1;
      r_rd_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_oe_n  <= (w_state_nxt == ST_IDLE);
      r_rd_n  <= (w_state_nxt != ST_READ);
    end
  end

  // --------------------------------------------------------------------------
  // FWFT FIFO
  // --------------------------------------------------------------------------
  // Storage needs no reset: contents are only visible while level != 0.
  always_ff @(posedge ft6_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {ft6_be_in, ft6_data_in};
    end
  end

  always_ff @(posedge ft6_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rx_count <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push) r_rx_count <= r_rx_count + 32'd1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign {out_be, out_data} = r_mem[r_rd_ptr];
  assign out_valid          = (r_level != '0);
  assign level              = r_level;
  assign rx_count           = r_rx_count;
  assign ovf                = r_ovf;
  assign ft6_oe_n           = r_oe_n;
  assign ft6_rd_n           = r_rd_n;

endmodule
`default_nettype wire

// File: tb/tb_ft6_read.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ft6_read
//  Purpose  : Directed self-checking bench for ft6_read (DEPTH=8,
//             RD_MARGIN=2). A small FT601 source model supplies words from
//             a table; every popped word is compared against that table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ft6_read;

  logic        ft6_clk;
  logic        rst_n;
  logic        ft6_rxf_n;
  logic [31:0] ft6_data_in;
  logic [3:0]  ft6_be_in;
  logic        ft6_oe_n;
  logic        ft6_rd_n;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic [31:0] rx_count;
  logic        ovf;

  ft6_read #(.DEPTH(8), .RD_MARGIN(2), .DW(32)) u_dut (
    .ft6_clk    (ft6_clk),
    .rst_n      (rst_n),
    .ft6_rxf_n  (ft6_rxf_n),
    .ft6_data_in(ft6_data_in),
    .ft6_be_in  (ft6_be_in),
    .ft6_oe_n   (ft6_oe_n),
    .ft6_rd_n   (ft6_rd_n),
    .out_data   (out_data),
    .out_be     (out_be),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .rx_count   (rx_count),
    .ovf        (ovf)
  );

  initial ft6_clk = 1'b0;
  always #5 ft6_clk = ~ft6_clk;

  int checks   = 0;
  int failures = 0;

  // Source table and progress indices
  logic [31:0] src_d [64];
  logic [3:0]  src_b [64];
  int          src_n   = 0;   // words the FT601 currently holds (prefix of table)
  int          src_idx = 0;   // next word the FT601 offers
  int          pop_idx = 0;   // next word expected downstream
  logic        hold_hi = 1'b0;
  int          base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ft6_rxf_n   = hold_hi || (src_idx >= src_n);
    ft6_data_in = (src_idx < src_n) ? src_d[src_idx] : 32'hDEAD_BEEF;
    ft6_be_in   = (src_idx < src_n) ? src_b[src_idx] : 4'h0;
  endtask

  // Called while the clock is low: samples pre-edge values, crosses one
  // rising edge, scores any capture/pop, then re-drives at the falling edge.
  task automatic tick();
    logic        cap, pop;
    logic [31:0] pd;
    logic [3:0]  pb;
    cap = !ft6_rd_n && !ft6_rxf_n;
    pop = out_valid && out_ready;
    pd  = out_data;
    pb  = out_be;
    @(posedge ft6_clk);
    #1;
    if (cap) src_idx++;
    if (pop) begin
      check("pop_data", pd, src_d[pop_idx]);
      check("pop_be", {28'd0, pb}, {28'd0, src_b[pop_idx]});
      pop_idx++;
    end
    @(negedge ft6_clk);
    drive();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src_d[i] = {4{8'(8'h11 * (i + 1))}};
      src_b[i] = 4'hF;
    end
    src_d[4] = 32'h0000_00AB; src_b[4] = 4'b0001;
    for (int i = 5; i < 11; i++) begin
      src_d[i] = 32'hA000_0000 + 32'(i);
      src_b[i] = 4'(i);
    end
    for (int i = 11; i < 31; i++) begin
      src_d[i] = 32'hB000_0000 + 32'(i);
      src_b[i] = 4'hF - 4'(i % 16);
    end
    for (int i = 31; i < 64; i++) begin
      src_d[i] = 32'hC000_0000 + 32'(i);
      src_b[i] = 4'hC;
    end

    // ---------------- reset state ----------------
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive();
    repeat (3) @(negedge ft6_clk);
    check("rst_oe_n", {31'd0, ft6_oe_n}, 32'd1);
    check("rst_rd_n", {31'd0, ft6_rd_n}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_rx_count", rx_count, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_oe_n", {31'd0, ft6_oe_n}, 32'd1);

    // ---------------- burst of 4 with push+pop ----------------
    out_ready = 1'b1;
    src_n = 4;
    drive();
    tick();
    check("burst_oe_low", {31'd0, ft6_oe_n}, 32'd0);
    check("burst_rd_still_high", {31'd0, ft6_rd_n}, 32'd1);
    tick();
    check("burst_rd_low", {31'd0, ft6_rd_n}, 32'd0);
    tick();
    check("burst_first_level", {28'd0, level}, 32'd1);
    check("burst_first_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pushpop_level", {28'd0, level}, 32'd1);
    end
    tick();
    check("burst_turn_rd_n", {31'd0, ft6_rd_n}, 32'd1);
    check("burst_turn_oe_n", {31'd0, ft6_oe_n}, 32'd0);
    check("burst_drained", {28'd0, level}, 32'd0);
    tick();
    check("burst_idle_oe_n", {31'd0, ft6_oe_n}, 32'd1);
    check("burst_rx_count", rx_count, 32'd4);
    check("burst_pop_count", pop_idx, 32'd4);

    // ---------------- partial byte enables ----------------
    out_ready = 1'b0;
    src_n = 5;
    drive();
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("be_valid", {31'd0, out_valid}, 32'd1);
    check("be_data", out_data, 32'h0000_00AB);
    check("be_be", {28'd0, out_be}, 32'd1);
    tick();
    check("be_hold_data", out_data, 32'h0000_00AB);
    check("be_hold_be", {28'd0, out_be}, 32'd1);
    out_ready = 1'b1;
    repeat (4) tick();
    check("be_popped", pop_idx, 32'd5);

    // ---------------- one-edge gap mid-burst ----------------
    src_n = 11;
    drive();
    for (int i = 0; i < 20 && src_idx < 7; i++) tick();
    check("gap_two_taken", src_idx, 32'd7);
    hold_hi = 1'b1;
    drive();
    hold_hi = 1'b0;
    tick();
    check("gap_no_push", src_idx, 32'd7);
    check("gap_turn_rd_n", {31'd0, ft6_rd_n}, 32'd1);
    check("gap_turn_oe_n", {31'd0, ft6_oe_n}, 32'd0);
    tick();
    check("gap_idle_oe_n", {31'd0, ft6_oe_n}, 32'd1);
    tick();
    check("gap_reopen_oe_n", {31'd0, ft6_oe_n}, 32'd0);
    for (int i = 0; i < 40 && pop_idx < 11; i++) tick();
    check("gap_all_popped", pop_idx, 32'd11);
    check("gap_rx_count", rx_count, 32'd11);

    // ---------------- backpressure, 20 words ----------------
    repeat (3) tick();
    out_ready = 1'b0;
    src_n = 31;
    drive();
    repeat (30) tick();
    check("bp_level_full", {28'd0, level}, 32'd8);
    check("bp_rd_n_high", {31'd0, ft6_rd_n}, 32'd1);
    check("bp_ovf", {31'd0, ovf}, 32'd0);
    check("bp_rx_count", rx_count, 32'd19);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && pop_idx < 31; i++) tick();
    check("bp_all_popped", pop_idx, 32'd31);
    check("bp_ovf_end", {31'd0, ovf}, 32'd0);
    check("bp_rx_count_end", rx_count, 32'd31);
    repeat (3) tick();
    check("bp_level_end", {28'd0, level}, 32'd0);

    // ---------------- reset mid-burst ----------------
    out_ready = 1'b0;
    src_n = 40;
    drive();
    for (int i = 0; i < 20 && src_idx < 34; i++) tick();
    check("mid_rd_active", {31'd0, ft6_rd_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_oe_n", {31'd0, ft6_oe_n}, 32'd1);
    check("mid_rst_rd_n", {31'd0, ft6_rd_n}, 32'd1);
    @(negedge ft6_clk);
    src_n   = src_idx;
    pop_idx = src_idx;
    drive();
    @(negedge ft6_clk);
    rst_n = 1'b1;
    tick();
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    check("mid_level", {28'd0, level}, 32'd0);
    check("mid_rx_count", rx_count, 32'd0);
    check("mid_ovf", {31'd0, ovf}, 32'd0);
    check("mid_oe_n_idle", {31'd0, ft6_oe_n}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
